// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: synchronous FIFO with registered flags, standard or first-word-fall-through read
module fifo_sync_fwft #(
  parameter int FIFO_WIDTH             = 8,
  parameter int FIFO_DEPTH             = 32,
  parameter int FWFT_MODE              = 0,
  parameter int ALMOST_FULL_THRESHOLD  = 4,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_enable,
  input  logic [FIFO_WIDTH-1:0]         wr_data,
  input  logic                          rd_enable,
  output logic [FIFO_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic          w_wr, w_rd, w_load, w_valid_nxt;
  logic [AW:0]   w_level_nxt, w_mem_cnt;
  // Accept decisions use registered flags only; in FWFT mode the output register counts in the level,
  // so the array holds level minus the prefetched word and refills the output whenever it is free or popped.
  always_comb begin
    w_wr        = wr_enable && !fifo_full;
    w_rd        = rd_enable && !fifo_empty;
    w_mem_cnt   = fifo_level - {{AW{1'b0}}, rd_valid};
    w_load      = (FWFT_MODE != 0) ? (w_mem_cnt != '0 && (!rd_valid || w_rd)) : w_rd;
    w_valid_nxt = (FWFT_MODE != 0) ? (w_load || (rd_valid && !w_rd)) : w_rd;
    w_level_nxt = fifo_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
  end
  // Storage array: no reset needed since pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr) r_mem[r_wptr] <= wr_data;
  end
  // Pointers, output register, level and flags; flags derive from the next-state level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      rd_data           <= '0;
      rd_valid          <= 1'b0;
      fifo_level        <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
    end else if (flush) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      rd_valid          <= 1'b0;
      fifo_level        <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_load) begin
        rd_data <= r_mem[r_rptr];
        r_rptr  <= r_rptr + 1'b1;
      end
      rd_valid          <= w_valid_nxt;
      fifo_level        <= w_level_nxt;
      fifo_full         <= w_level_nxt == (AW+1)'(FIFO_DEPTH);
      fifo_empty        <= (FWFT_MODE != 0) ? !w_valid_nxt : (w_level_nxt == '0);
      fifo_almost_full  <= w_level_nxt >= (AW+1)'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);
      fifo_almost_empty <= w_level_nxt <= (AW+1)'(ALMOST_EMPTY_THRESHOLD);
      if (wr_enable && fifo_full) overflow <= 1'b1;
      if (rd_enable && fifo_empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb_fifo_sync_fwft: directed checks of both read modes at depth 8
module tb_fifo_sync_fwft;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, wr_enable = 1'b0, rd_enable = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd0, rd1;
  logic [3:0] lv0, lv1;
  logic rv0, fu0, em0, af0, ae0, ov0, un0;
  logic rv1, fu1, em1, af1, ae1, ov1, un1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fifo_sync_fwft #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .FWFT_MODE(0), .ALMOST_FULL_THRESHOLD(2), .ALMOST_EMPTY_THRESHOLD(1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_enable(wr_enable), .wr_data(wr_data), .rd_enable(rd_enable),
    .rd_data(rd0), .rd_valid(rv0), .fifo_full(fu0), .fifo_empty(em0), .fifo_almost_full(af0),
    .fifo_almost_empty(ae0), .fifo_level(lv0), .overflow(ov0), .underflow(un0));

  fifo_sync_fwft #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .FWFT_MODE(1), .ALMOST_FULL_THRESHOLD(2), .ALMOST_EMPTY_THRESHOLD(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_enable(wr_enable), .wr_data(wr_data), .rd_enable(rd_enable),
    .rd_data(rd1), .rd_valid(rv1), .fifo_full(fu1), .fifo_empty(em1), .fifo_almost_full(af1),
    .fifo_almost_empty(ae1), .fifo_level(lv1), .overflow(ov1), .underflow(un1));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_enable = 1'b1; wr_data = 8'hAA; rd_enable = 1'b1;
    cyc();
    rst = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    tests++; if ({rd0, lv0} !== 12'h000) begin fails++; $display("FAIL reset_data_level got %h exp 000", {rd0, lv0}); end
    tests++; if ({rv0, em0, ae0, af0, fu0, ov0, un0} !== 7'b0110000) begin fails++; $display("FAIL reset_flags0 got %b exp 0110000", {rv0, em0, ae0, af0, fu0, ov0, un0}); end
    tests++; if ({rv1, em1, ae1, af1, fu1, ov1, un1, lv1} !== 11'b0110000_0000) begin fails++; $display("FAIL reset_flags1 got %b exp 01100000000", {rv1, em1, ae1, af1, fu1, ov1, un1, lv1}); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_enable = 1'b1; wr_data = 8'(i);
      cyc();
      tests++; if (lv0 !== 4'(i)) begin fails++; $display("FAIL fill_level%0d got %0d exp %0d", i, lv0, i); end
      tests++; if ({ae0, af0, fu0} !== {i <= 1, i >= 6, i == 8}) begin fails++; $display("FAIL fill_flags%0d got %b exp %b", i, {ae0, af0, fu0}, {i <= 1, i >= 6, i == 8}); end
    end
    wr_data = 8'hFF;
    cyc();
    wr_enable = 1'b0;
    tests++; if ({lv0, fu0, ov0} !== {4'd8, 1'b1, 1'b1}) begin fails++; $display("FAIL overflow_drop got %b exp 100011", {lv0, fu0, ov0}); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_enable = 1'b1;
      cyc();
      rd_enable = 1'b0;
      tests++; if ({rv0, rd0} !== {1'b1, 8'(i)}) begin fails++; $display("FAIL drain_data%0d got %h exp 1%02h", i, {rv0, rd0}, i); end
      cyc();
      tests++; if (rv0 !== 1'b0) begin fails++; $display("FAIL drain_pulse%0d got %b exp 0", i, rv0); end
    end
    tests++; if ({em0, lv0} !== 5'b1_0000) begin fails++; $display("FAIL drain_empty got %b exp 10000", {em0, lv0}); end
    rd_enable = 1'b1;
    cyc();
    rd_enable = 1'b0;
    tests++; if ({un0, rv0, lv0} !== 6'b10_0000) begin fails++; $display("FAIL underflow got %b exp 100000", {un0, rv0, lv0}); end
  endtask

  task automatic test_wrap();
    int lvl;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      wr_enable = c < 20; wr_data = 8'h10 + 8'(c); rd_enable = c >= 3;
      cyc();
      lvl = (c < 20 ? c + 1 : 20) - (c >= 3 ? c - 2 : 0);
      if (c >= 3) begin
        tests++; if ({rv0, rd0} !== {1'b1, 8'h10 + 8'(c - 3)}) begin fails++; $display("FAIL wrap_data%0d got %h exp 1%02h", c, {rv0, rd0}, 8'h10 + 8'(c - 3)); end
      end
      tests++; if (lv0 !== 4'(lvl)) begin fails++; $display("FAIL wrap_level%0d got %0d exp %0d", c, lv0, lvl); end
      if (c >= 3 && c < 20) begin
        tests++; if ({em0, ae0, af0, fu0} !== 4'b0000) begin fails++; $display("FAIL wrap_flags%0d got %b exp 0000", c, {em0, ae0, af0, fu0}); end
      end
    end
    wr_enable = 1'b0; rd_enable = 1'b0;
    tests++; if (em0 !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", em0); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wr_enable = 1'b1; wr_data = 8'(i);
      cyc();
    end
    wr_data = 8'hEE; rd_enable = 1'b1;
    cyc();
    wr_enable = 1'b0; rd_enable = 1'b0;
    tests++; if ({lv0, ov0, fu0} !== {4'd7, 1'b1, 1'b0}) begin fails++; $display("FAIL full_rw got %b exp 011110", {lv0, ov0, fu0}); end
    tests++; if ({rv0, rd0} !== 9'h101) begin fails++; $display("FAIL full_rw_data got %h exp 101", {rv0, rd0}); end
    rd_enable = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    rd_enable = 1'b0;
    tests++; if ({rd0, em0} !== {8'h08, 1'b1}) begin fails++; $display("FAIL full_rw_tail got %h exp 011", {rd0, em0}); end
  endtask

  task automatic test_fwft();
    do_reset();
    wr_enable = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_enable = 1'b0;
    tests++; if ({rv1, em1, lv1} !== 6'b01_0001) begin fails++; $display("FAIL fwft_stage got %b exp 010001", {rv1, em1, lv1}); end
    cyc();
    tests++; if ({rv1, em1, rd1, lv1} !== {2'b10, 8'hA5, 4'd1}) begin fails++; $display("FAIL fwft_first got %h exp 2a51", {rv1, em1, rd1, lv1}); end
    cyc(); cyc();
    tests++; if ({rv1, rd1} !== 9'h1A5) begin fails++; $display("FAIL fwft_hold got %h exp 1a5", {rv1, rd1}); end
    rd_enable = 1'b1;
    cyc();
    rd_enable = 1'b0;
    tests++; if ({rv1, em1, lv1} !== 6'b01_0000) begin fails++; $display("FAIL fwft_pop got %b exp 010000", {rv1, em1, lv1}); end
    for (int i = 0; i < 4; i++) begin
      wr_enable = 1'b1; wr_data = 8'hB0 + 8'(i);
      cyc();
    end
    wr_enable = 1'b0;
    cyc();
    tests++; if (lv1 !== 4'd4) begin fails++; $display("FAIL fwft_level got %0d exp 4", lv1); end
    for (int i = 0; i < 4; i++) begin
      tests++; if ({rv1, rd1} !== {1'b1, 8'hB0 + 8'(i)}) begin fails++; $display("FAIL fwft_burst%0d got %h exp 1%02h", i, {rv1, rd1}, 8'hB0 + 8'(i)); end
      rd_enable = 1'b1;
      cyc();
    end
    rd_enable = 1'b0;
    tests++; if ({rv1, em1, un1} !== 3'b010) begin fails++; $display("FAIL fwft_drained got %b exp 010", {rv1, em1, un1}); end
  endtask

  task automatic test_flush();
    do_reset();
    wr_enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wr_data = 8'(i);
      cyc();
    end
    wr_enable = 1'b0; rd_enable = 1'b1;
    cyc(); cyc(); cyc();
    rd_enable = 1'b0;
    tests++; if ({lv0, ov0} !== 5'b0101_1) begin fails++; $display("FAIL flush_pre got %b exp 01011", {lv0, ov0}); end
    flush = 1'b1; wr_enable = 1'b1; wr_data = 8'h66; rd_enable = 1'b1;
    cyc();
    flush = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    tests++; if ({lv0, em0, ae0, af0, fu0, rv0, ov0} !== 10'b0000_1100_01) begin fails++; $display("FAIL flush_state got %b exp 0000110001", {lv0, em0, ae0, af0, fu0, rv0, ov0}); end
    tests++; if ({lv1, em1, rv1} !== 6'b0000_10) begin fails++; $display("FAIL flush_fwft got %b exp 000010", {lv1, em1, rv1}); end
    wr_enable = 1'b1; wr_data = 8'h77;
    cyc();
    wr_enable = 1'b0; rd_enable = 1'b1;
    cyc();
    rd_enable = 1'b0;
    tests++; if ({rv0, rd0} !== 9'h177) begin fails++; $display("FAIL flush_reuse got %h exp 177", {rv0, rd0}); end
  endtask

  task automatic test_reset_burst();
    wr_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h30 + 8'(i);
      cyc();
    end
    rst = 1'b1; wr_data = 8'h99;
    cyc();
    rst = 1'b0; wr_enable = 1'b0;
    tests++; if ({rd0, lv0, rv0, em0, ae0, af0, fu0, ov0, un0} !== {8'h00, 4'd0, 7'b0110000}) begin fails++; $display("FAIL burst_reset got %b exp 0000000000000110000", {rd0, lv0, rv0, em0, ae0, af0, fu0, ov0, un0}); end
    wr_enable = 1'b1; wr_data = 8'h55;
    cyc();
    wr_enable = 1'b0; rd_enable = 1'b1;
    cyc();
    rd_enable = 1'b0;
    tests++; if ({rv0, rd0, lv0} !== {1'b1, 8'h55, 4'd0}) begin fails++; $display("FAIL burst_first got %h exp 1550", {rv0, rd0, lv0}); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_rw();
    test_fwft();
    test_flush();
    test_reset_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_sync_fwft.md
FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter FIFO_WIDTH, default 8: data width in bits, 1 or more.
REQ-003 Parameter FIFO_DEPTH, default 32: capacity in words; a power of 2, 4 or more.
REQ-004 Parameter FWFT_MODE, default 0: 0 = standard read-request mode, 1 = first-word-fall-through.
REQ-005 Parameter ALMOST_FULL_THRESHOLD, default 4: free-space margin for almost-full; 1 to FIFO_DEPTH-1.
REQ-006 Parameter ALMOST_EMPTY_THRESHOLD, default 1: fill margin for almost-empty; 0 to FIFO_DEPTH-1.
REQ-007 Define addr_bits = clog2(FIFO_DEPTH).
REQ-008 clk  input  1  sole clock; all logic is on its rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 flush  input  1  synchronous clear of contents.
REQ-011 wr_enable  input  1  write request.
REQ-012 wr_data  input  FIFO_WIDTH  write data.
REQ-013 rd_enable  input  1  read request (mode 0) or pop/acknowledge (mode 1).
REQ-014 rd_data  output  FIFO_WIDTH  read data, registered.
REQ-015 rd_valid  output  1  rd_data holds a valid word.
REQ-016 fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty  output  1 each  status flags, registered.
REQ-017 fifo_level  output  addr_bits+1  stored word count, 0 to FIFO_DEPTH.
REQ-018 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-019 Writes: accepted iff wr_enable=1 and fifo_full=0; a write while full is dropped, overflow<=1, storage unchanged.
REQ-020 Writes: the write decision uses registered fifo_full only; a write while full is dropped even if a read is accepted in the same cycle.
REQ-021 Reads: accepted iff rd_enable=1 and fifo_empty=0; a read while empty is ignored, underflow<=1.
REQ-022 Reads: a read while empty is ignored even if a write is accepted in the same cycle.
REQ-023 Level: fifo_level(next) = level + accepted write - accepted read.
REQ-024 Level: simultaneous accepted read and write leaves the level unchanged.
REQ-025 Pointers: the write and read pointers SHALL wrap modulo FIFO_DEPTH; word order is strictly preserved across wrap.
REQ-026 Flags: all flags SHALL be registered from the next-state level, so they change on the same edge as fifo_level.
REQ-027 Flag definitions:
- fifo_full = (level == FIFO_DEPTH)
- fifo_almost_full = (level >= FIFO_DEPTH - ALMOST_FULL_THRESHOLD)
- fifo_almost_empty = (level <= ALMOST_EMPTY_THRESHOLD)
REQ-028 Mode 0: an accepted read at edge k SHALL present the head word on rd_data with rd_valid=1 after edge k+1.
REQ-029 Mode 0: rd_valid SHALL be a one-cycle pulse per accepted read; rd_data holds its last value otherwise; fifo_empty = (level == 0).
REQ-030 Mode 1: whenever a word is stored, the head word SHALL be presented on rd_data with rd_valid=1, and fifo_empty = !rd_valid.
REQ-031 Mode 1: rd_enable with rd_valid=1 pops the head.
REQ-032 Mode 1: the next word SHALL appear no later than 2 edges after the pop, and back-to-back pops at full rate SHALL sustain one word per cycle.
REQ-033 Mode 1: a word written into an empty FIFO at edge k SHALL show rd_valid=1 after edge k+2.
REQ-034 Mode 1: the prefetched output word SHALL count in fifo_level; total capacity is FIFO_DEPTH.
REQ-035 Flush: flush=1 SHALL clear pointers, level and rd_valid, and set all flags to their reset values on the next edge.
REQ-036 Flush: flush SHALL have priority over wr_enable and rd_enable in the same cycle.
REQ-037 Flush: flush SHALL NOT clear overflow or underflow.

Reset
REQ-038 rst SHALL have priority over everything.
REQ-039 After one rst edge:
- rd_data=0, rd_valid=0, fifo_level=0
- fifo_empty=1, fifo_almost_empty=1
- fifo_full=0, fifo_almost_full=0
- overflow=0, underflow=0
REQ-040 Requests present during the rst cycle SHALL be ignored.
REQ-041 Reset asserted mid-burst SHALL discard all contents; the first accepted write after rst deasserts is read first.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=8, ALMOST_FULL_THRESHOLD=2, ALMOST_EMPTY_THRESHOLD=1)
REQ-042 Mode 0, write 0x01..0x08 from reset -> level steps 1..8; almost_empty drops at level 2; almost_full rises at level 6; full at 8; 9th write 0xFF dropped, overflow=1, level stays 8.
REQ-043 Mode 0, 8 reads after REQ-042 -> rd_data 0x01..0x08, each one cycle after its rd_enable with a rd_valid pulse; empty=1 after the last; a 9th read sets underflow=1 with no rd_valid pulse.
REQ-044 Mode 0, 20 interleaved writes/reads of 0x10..0x23 at levels 0..3 -> identical output order across pointer wrap; simultaneous read+write at level 3 keeps level 3 and flags steady.
REQ-045 At full, simultaneous read+write -> write dropped, read accepted, level 7, overflow=1, full=0.
REQ-046 Mode 1, one write 0xA5 into empty -> rd_valid=1, rd_data=0xA5 after edge k+2, held until rd_enable; pop -> rd_valid=0, empty=1 next cycle; 4 words popped every cycle -> 4 consecutive valid words.
REQ-047 At level 5 with overflow=1, flush -> next cycle level 0, empty=1, overflow still 1; rst during a write burst -> all REQ-039 values next edge, burst-cycle writes absent on readback.
